muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_unit.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: 32-cycle shift-add multiplier and restoring divider.
// Optional macro MULDIV_EARLY_OUT_EN finishes trivial/special operands without iterating.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic [2:0]  op;
    logic [31:0] raw_a;
    logic        neg_a, neg_p, zero_b;
    logic [63:0] acc, md;
    logic [31:0] sr, rem;

    logic [63:0] acc_nx, md_nx;
    logic [31:0] sr_nx, rem_nx;
    logic [32:0] rem_sh;

    logic        accept, sa, sb, na, nb;
    logic [31:0] mag_a, mag_b;

    function automatic logic [31:0] magnitude(input logic [31:0] x, input logic neg);
        return neg ? (~x + 32'd1) : x;
    endfunction

    function automatic logic a_is_signed(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b110);
    endfunction

    function automatic logic b_is_signed(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b100) || (f == 3'b110);
    endfunction

    // Sign fix-up and selection of the architectural result after the last iteration.
    function automatic logic [31:0] finish_op(
        input logic [2:0]  f,
        input logic [63:0] prod,
        input logic [31:0] quo,
        input logic [31:0] rmd,
        input logic [31:0] src_a,
        input logic        np,
        input logic        na_f,
        input logic        bz
    );
        logic [63:0] sprod;
        logic [31:0] q, r, res;
        sprod = np ? (~prod + 64'd1) : prod;
        q     = np ? (~quo + 32'd1) : quo;
        r     = na_f ? (~rmd + 32'd1) : rmd;
        case (f)
            3'b000:                 res = sprod[31:0];
            3'b001, 3'b010, 3'b011: res = sprod[63:32];
            3'b100, 3'b101:         res = bz ? 32'hFFFF_FFFF : q;
            default:                res = bz ? src_a : r;
        endcase
        return res;
    endfunction

`ifdef MULDIV_EARLY_OUT_EN
    function automatic logic special_hit(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (f[2])
            return (y == 32'd0) || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF);
        return (x == 32'd0) || (y == 32'd0);
    endfunction

    function automatic logic [31:0] special_value(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        if (!f[2])
            return 32'd0;
        if (y == 32'd0)
            return f[1] ? x : 32'hFFFF_FFFF;
        return f[1] ? 32'd0 : 32'h8000_0000;
    endfunction
`endif

    assign accept = start && (state != CALC);
    assign sa     = a_is_signed(funct3);
    assign sb     = b_is_signed(funct3);
    assign na     = sa && a[31];
    assign nb     = sb && b[31];
    assign mag_a  = magnitude(a, na);
    assign mag_b  = magnitude(b, nb);

    assign busy = (state == CALC);
    assign done = (state == DONE);

    // One iteration: shift-add for multiply, restoring subtract for divide.
    always_comb begin
        acc_nx = acc;
        md_nx  = md;
        sr_nx  = sr;
        rem_nx = rem;
        rem_sh = {rem, sr[31]};
        if (op[2]) begin
            if (rem_sh >= {1'b0, md[31:0]}) begin
                rem_nx = rem_sh[31:0] - md[31:0];
                sr_nx  = {sr[30:0], 1'b1};
            end else begin
                rem_nx = rem_sh[31:0];
                sr_nx  = {sr[30:0], 1'b0};
            end
        end else begin
            if (sr[0])
                acc_nx = acc + md;
            md_nx = {md[62:0], 1'b0};
            sr_nx = {1'b0, sr[31:1]};
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx = CALC;
`ifdef MULDIV_EARLY_OUT_EN
                    if (special_hit(funct3, a, b))
                        state_nx = DONE;
`endif
                end else begin
                    state_nx = IDLE;
                end
            end
            CALC: begin
                if (cnt == 5'd31)
                    state_nx = DONE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= 5'd0;
            op     <= 3'd0;
            raw_a  <= 32'd0;
            neg_a  <= 1'b0;
            neg_p  <= 1'b0;
            zero_b <= 1'b0;
            acc    <= 64'd0;
            md     <= 64'd0;
            sr     <= 32'd0;
            rem    <= 32'd0;
            result <= 32'd0;
        end else begin
            state <= state_nx;
            if (accept) begin
                // Divide keeps divisor in md and dividend/quotient in sr; multiply the reverse.
                op     <= funct3;
                raw_a  <= a;
                neg_a  <= na;
                neg_p  <= na ^ nb;
                zero_b <= (b == 32'd0);
                cnt    <= 5'd0;
                acc    <= 64'd0;
                rem    <= 32'd0;
                md     <= {32'd0, funct3[2] ? mag_b : mag_a};
                sr     <= funct3[2] ? mag_a : mag_b;
`ifdef MULDIV_EARLY_OUT_EN
                if (special_hit(funct3, a, b))
                    result <= special_value(funct3, a, b);
`endif
            end else if (state == CALC) begin
                cnt <= cnt + 5'd1;
                acc <= acc_nx;
                md  <= md_nx;
                sr  <= sr_nx;
                rem <= rem_nx;
                if (cnt == 5'd31)
                    result <= finish_op(op, acc_nx, sr_nx, rem_nx, raw_a, neg_p, neg_a, zero_b);
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M vectors, reset abort and back-to-back issue.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] result;

    typedef struct {
        logic [31:0] res;
        int          at;
        string       nm;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    muldiv_unit dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Expected latency in cycles from the sampling edge to the done cycle.
    function automatic int latency(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_EARLY_OUT_EN
        if (f[2] && (y == 32'd0 || (!f[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF)))
            return 1;
        if (!f[2] && (x == 32'd0 || y == 32'd0))
            return 1;
`endif
        return 33;
    endfunction

    // Monitor: the cycle index at a falling edge is the number of rising edges so far plus one.
    always @(negedge clk) begin
        if (done) begin
            if (sbq.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done with result %h at cycle %0d, required no done", result, cyc + 1);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                check_val({e.nm, "_result"}, result, e.res);
                check_int({e.nm, "_cycle"}, cyc + 1, e.at);
            end
        end
    end

    // Called on a falling edge while the unit can accept; operands are scrambled after capture.
    task automatic issue(input string nm, input logic [2:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] req, input bit track);
        exp_t e;
        start  = 1'b1;
        funct3 = f;
        a      = x;
        b      = y;
        @(negedge clk);
        if (track) begin
            e.res = req;
            e.at  = cyc + latency(f, x, y);
            e.nm  = nm;
            sbq.push_back(e);
        end
        start  = 1'b0;
        funct3 = 3'($urandom);
        a      = $urandom;
        b      = $urandom;
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while (!done && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: got no done after %0d cycles, required done", nm, k);
        end
    endtask

    task automatic run_vec(input string nm, input logic [2:0] f, input logic [31:0] x,
                           input logic [31:0] y, input logic [31:0] req);
        issue(nm, f, x, y, req, 1'b1);
        wait_done(nm);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        funct3 = 3'd0;
        a      = 32'd0;
        b      = 32'd0;
        @(negedge clk);
        check_val("reset_busy", {31'd0, busy}, 32'd0);
        check_val("reset_done", {31'd0, done}, 32'd0);
        check_val("reset_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_vec("mul_neg",      3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_vec("mulh_neg",     3'b001, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_vec("mulhu_max",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_vec("mulhsu_max",   3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_vec("mulh_min",     3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run_vec("mul_zero",     3'b000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000);
        run_vec("div_neg",      3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD);
        run_vec("rem_neg",      3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF);
        run_vec("divu",         3'b101, 32'd100,       32'd7,         32'd14);
        run_vec("remu",         3'b111, 32'd100,       32'd7,         32'd2);
        run_vec("div_negb",     3'b100, 32'd20,        32'hFFFF_FFFD, 32'hFFFF_FFFA);
        run_vec("rem_negb",     3'b110, 32'd20,        32'hFFFF_FFFD, 32'd2);
        run_vec("div_by0",      3'b100, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF);
        run_vec("rem_by0",      3'b110, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678);
        run_vec("div_ovf",      3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_vec("rem_ovf",      3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);
        run_vec("divu_by0",     3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF);
        run_vec("remu_by0",     3'b111, 32'hCAFE_0001, 32'd0,         32'hCAFE_0001);

        repeat (5) @(negedge clk);
        check_val("result_hold", result, 32'hCAFE_0001);

        // Abort a divide at iteration 10; no done may follow.
        issue("abort", 3'b101, 32'd100, 32'd7, 32'd0, 1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        check_val("abort_busy", {31'd0, busy}, 32'd0);
        check_val("abort_done", {31'd0, done}, 32'd0);
        check_val("abort_result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        run_vec("post_reset_divu", 3'b101, 32'd9, 32'd3, 32'd3);

        // Back-to-back: second start lands in the DONE cycle, then start and operands toggle while busy.
        issue("b2b_first", 3'b000, 32'd6, 32'd7, 32'd42, 1'b1);
        wait_done("b2b_first");
        issue("b2b_second", 3'b101, 32'd1000, 32'd10, 32'd100, 1'b1);
        for (int i = 0; i < 20; i++) begin
            start  = ~start;
            a      = $urandom;
            b      = $urandom;
            funct3 = 3'($urandom);
            @(negedge clk);
        end
        start = 1'b0;
        wait_done("b2b_second");
        repeat (40) @(negedge clk);
        check_int("queue_empty", sbq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
